vmicro16_cluster_apb_arbiter: RTL and testbench

- Round-robin arbiter that shares the cluster's single upstream APB master port (to soc.IC_DMEM) among NCORES vmicro16_core APB masters.
- Sits between the per-core APB buses and the cluster's M_* port.
- Sequences one complete APB transfer (SETUP then ACCESS) per grant and routes the response back to the granted core only.
- Includes a transfer watchdog so a slave that never returns PREADY cannot hang the cluster.

---
 rtl/vmicro16_cluster_apb_arbiter_if.sv | 32 +++
 rtl/vmicro16_cluster_apb_arbiter.sv | 155 +++++++++++++++
 tb/tb_vmicro16_cluster_apb_arbiter.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vmicro16_cluster_apb_arbiter_if.sv
// APB bundle shared by the cluster arbiter and its neighbours.
//
// N lanes of APB are carried side by side. Lane c uses
// PADDR[c*BUS_WIDTH +: BUS_WIDTH] and PWDATA/PRDATA[c*DATA_WIDTH +: DATA_WIDTH].
// The per-core side uses N = NCORES; the upstream side uses N = 1.
//
// Modports:
//   master - drives PADDR, PWRITE, PSELx, PENABLE, PWDATA; receives PRDATA, PREADY
//   slave  - receives the request signals; drives PRDATA, PREADY
interface vmicro16_cluster_apb_arbiter_if #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 16,
  parameter int N          = 1
);
  logic [N*BUS_WIDTH-1:0]  PADDR;
  logic [N-1:0]            PWRITE;
  logic [N-1:0]            PSELx;
  logic [N-1:0]            PENABLE;
  logic [N*DATA_WIDTH-1:0] PWDATA;
  logic [N*DATA_WIDTH-1:0] PRDATA;
  logic [N-1:0]            PREADY;

  modport master (
    output PADDR, PWRITE, PSELx, PENABLE, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWRITE, PSELx, PENABLE, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/vmicro16_cluster_apb_arbiter.sv
// Round-robin arbiter sharing the cluster's single upstream APB master port
// among NCORES core APB masters. Each grant runs one full APB transfer
// (SETUP then ACCESS) upstream and routes the response to the granted core only.
// A watchdog aborts an ACCESS phase whose slave never answers.
//
// Ports:
//   clk         - rising-edge clock
//   reset       - asynchronous, active-high reset
//   s_apb       - per-core APB buses (slave view, NCORES lanes); PSELx is the request
//   m_apb       - upstream APB bus (master view, 1 lane)
//   grant       - one-hot current owner, 0 when idle
//   timeout_err - sticky flag, set by a watchdog abort, cleared only by reset
module vmicro16_cluster_apb_arbiter #(
  parameter int BUS_WIDTH      = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int NCORES         = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                  clk,
  input  logic                                  reset,
  vmicro16_cluster_apb_arbiter_if.slave         s_apb,
  vmicro16_cluster_apb_arbiter_if.master        m_apb,
  output logic [NCORES-1:0]                     grant,
  output logic                                  timeout_err
);

  localparam int IDX_W = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NCORES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic             WDOG_EN  = (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       last;
  logic [IDX_W-1:0]       gidx;
  logic [CNT_W-1:0]       wdog_cnt;
  logic [BUS_WIDTH-1:0]   paddr_q;
  logic                   pwrite_q;
  logic [DATA_WIDTH-1:0]  pwdata_q;
  logic                   psel_q;
  logic                   penable_q;

  logic                   req_any;
  logic [IDX_W-1:0]       pick;
  logic                   done_ok;
  logic                   done_to;

  // Saturating increment: the watchdog counter parks at its limit.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // First requester at or after last+1, wrapping; with NCORES = 1 this
  // always lands on core 0.
  always_comb begin
    int idx;
    req_any = 1'b0;
    pick    = last;
    idx     = 0;
    for (int i = 1; i <= NCORES; i++) begin
      idx = (int'(last) + i) % NCORES;
      if (!req_any && s_apb.PSELx[idx]) begin
        req_any = 1'b1;
        pick    = IDX_W'(idx);
      end
    end
  end

  // A real PREADY wins over a coincident watchdog expiry.
  assign done_ok = (state == ACCESS) && m_apb.PREADY[0];
  assign done_to = (state == ACCESS) && !m_apb.PREADY[0] && WDOG_EN &&
                   (wdog_cnt == CNT_MAX);

  // Response routing: only the granted lane ever sees PREADY/PRDATA.
  always_comb begin
    s_apb.PREADY = '0;
    s_apb.PRDATA = '0;
    if (done_ok) begin
      s_apb.PREADY[gidx]                           = 1'b1;
      s_apb.PRDATA[gidx*DATA_WIDTH +: DATA_WIDTH]  = m_apb.PRDATA;
    end else if (done_to) begin
      s_apb.PREADY[gidx]                           = 1'b1;
      s_apb.PRDATA[gidx*DATA_WIDTH +: DATA_WIDTH]  = {DATA_WIDTH{1'b1}};
    end
  end

  assign m_apb.PADDR   = paddr_q;
  assign m_apb.PWRITE  = pwrite_q;
  assign m_apb.PSELx   = psel_q;
  assign m_apb.PENABLE = penable_q;
  assign m_apb.PWDATA  = pwdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last        <= LAST_RST;
      gidx        <= '0;
      grant       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      wdog_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        // IDLE: arbitrate and capture the winner's request
        IDLE: begin
          if (req_any) begin
            gidx      <= pick;
            grant     <= NCORES'(1) << pick;
            paddr_q   <= s_apb.PADDR[pick*BUS_WIDTH +: BUS_WIDTH];
            pwrite_q  <= s_apb.PWRITE[pick];
            pwdata_q  <= s_apb.PWDATA[pick*DATA_WIDTH +: DATA_WIDTH];
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state     <= SETUP;
          end
        end
        // SETUP: one cycle of PSEL without PENABLE
        SETUP: begin
          penable_q <= 1'b1;
          wdog_cnt  <= '0;
          state     <= ACCESS;
        end
        // ACCESS: hold the transfer until PREADY or watchdog expiry
        ACCESS: begin
          if (done_ok || done_to) begin
            last      <= gidx;
            grant     <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state     <= IDLE;
            if (done_to) begin
              timeout_err <= 1'b1;
            end
          end else if (WDOG_EN) begin
            wdog_cnt <= sat_inc(wdog_cnt);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vmicro16_cluster_apb_arbiter.sv
module tb_vmicro16_cluster_apb_arbiter;
  localparam int BW = 16;
  localparam int DW = 16;
  localparam int NC = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NC-1:0] grant;
  logic timeout_err;

  logic [NC*BW-1:0] c_paddr   = '0;
  logic [NC-1:0]    c_pwrite  = '0;
  logic [NC-1:0]    c_psel    = '0;
  logic [NC-1:0]    c_penable = '0;
  logic [NC*DW-1:0] c_pwdata  = '0;
  logic             slv_ready = 1'b0;
  logic [DW-1:0]    slv_rdata = '0;

  vmicro16_cluster_apb_arbiter_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .N(NC)) s_bus ();
  vmicro16_cluster_apb_arbiter_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW), .N(1))  m_bus ();

  assign s_bus.PADDR   = c_paddr;
  assign s_bus.PWRITE  = c_pwrite;
  assign s_bus.PSELx   = c_psel;
  assign s_bus.PENABLE = c_penable;
  assign s_bus.PWDATA  = c_pwdata;
  assign m_bus.PREADY  = slv_ready;
  assign m_bus.PRDATA  = slv_rdata;

  vmicro16_cluster_apb_arbiter #(
    .BUS_WIDTH(BW), .DATA_WIDTH(DW), .NCORES(NC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_apb       (s_bus),
    .m_apb       (m_bus),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          core;
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   glog[$];
  int   pulse_cyc[$];
  int   rem[NC];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   slave_wait = 0;
  bit   slave_never = 1'b0;
  int   wcnt = 0;

  always @(posedge clk) cyc++;

  function automatic logic [15:0] slave_data(input logic [15:0] a);
    return (a == 16'h0010) ? 16'h1234 : (a ^ 16'hA5C3);
  endfunction

  // Upstream slave model: answers after slave_wait stall cycles of ACCESS.
  always @(posedge clk) begin
    #1;
    if (m_bus.PSELx[0] && m_bus.PENABLE[0] && !slave_never) begin
      if (wcnt >= slave_wait) begin
        slv_ready = 1'b1;
        slv_rdata = slave_data(m_bus.PADDR);
      end else begin
        slv_ready = 1'b0;
        slv_rdata = '0;
        wcnt++;
      end
    end else begin
      slv_ready = 1'b0;
      slv_rdata = '0;
      wcnt = 0;
    end
  end

  // Scoreboard consumer: every S_PREADY pulse must match the queue head.
  exp_t             mon_e;
  logic [NC*DW-1:0] mon_rd;
  logic [NC-1:0]    mon_oh;
  always @(negedge clk) begin
    if (!reset && (|s_bus.PREADY)) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pready: got %b, required no response", s_bus.PREADY);
      end else begin
        mon_e  = sb_q.pop_front();
        mon_oh = '0;
        mon_oh[mon_e.core] = 1'b1;
        mon_rd = '0;
        mon_rd[mon_e.core*DW +: DW] = mon_e.rdata;
        if (s_bus.PREADY !== mon_oh) begin
          n_bad++;
          $display("FAIL sb_pready: got %b, required %b", s_bus.PREADY, mon_oh);
        end
        n_cmp++;
        if (grant !== mon_oh) begin
          n_bad++;
          $display("FAIL sb_grant: got %b, required %b", grant, mon_oh);
        end
        n_cmp++;
        if (s_bus.PRDATA !== mon_rd) begin
          n_bad++;
          $display("FAIL sb_prdata: got %h, required %h", s_bus.PRDATA, mon_rd);
        end
        n_cmp++;
        if ({m_bus.PADDR, m_bus.PWRITE[0], m_bus.PWDATA} !== {mon_e.addr, mon_e.wr, mon_e.wdata}) begin
          n_bad++;
          $display("FAIL sb_upstream: got addr %h wr %b wdata %h, required addr %h wr %b wdata %h",
                   m_bus.PADDR, m_bus.PWRITE[0], m_bus.PWDATA, mon_e.addr, mon_e.wr, mon_e.wdata);
        end
        n_cmp++;
        if ({m_bus.PSELx[0], m_bus.PENABLE[0]} !== 2'b11) begin
          n_bad++;
          $display("FAIL sb_phase: got psel/penable %b%b, required 11", m_bus.PSELx[0], m_bus.PENABLE[0]);
        end
      end
    end
  end

  task automatic set_core(input int c, input logic [15:0] a, input logic w, input logic [15:0] d);
    c_paddr[c*BW +: BW]  = a;
    c_pwrite[c]          = w;
    c_pwdata[c*DW +: DW] = d;
    c_penable[c]         = 1'b0;
    c_psel[c]            = 1'b1;
  endtask

  task automatic push_exp(input int c, input logic [15:0] a, input logic w, input logic [15:0] d,
                          input logic [15:0] r);
    exp_t e;
    e.core = c; e.addr = a; e.wr = w; e.wdata = d; e.rdata = r;
    sb_q.push_back(e);
  endtask

  // Cores drop PSELx once their remaining transfer count reaches zero.
  task automatic drain(input int budget);
    int left;
    left = 0;
    for (int c = 0; c < NC; c++) left += rem[c];
    for (int k = 0; k < budget && left > 0; k++) begin
      @(negedge clk);
      for (int c = 0; c < NC; c++) begin
        if (s_bus.PREADY[c] && rem[c] > 0) begin
          rem[c]--;
          left--;
          glog.push_back(c);
          pulse_cyc.push_back(cyc);
          if (rem[c] == 0) c_psel[c] = 1'b0;
        end
      end
    end
    n_cmp++;
    if (left != 0) begin
      n_bad++;
      $display("FAIL drain_budget: got %0d transfers outstanding, required 0", left);
      c_psel = '0;
      for (int c = 0; c < NC; c++) rem[c] = 0;
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({m_bus.PSELx[0], m_bus.PENABLE[0], m_bus.PWRITE[0]} !== 3'b000 ||
        m_bus.PADDR !== '0 || m_bus.PWDATA !== '0) begin
      n_bad++;
      $display("FAIL reset_upstream: got sel %b en %b wr %b addr %h wdata %h, required all 0",
               m_bus.PSELx[0], m_bus.PENABLE[0], m_bus.PWRITE[0], m_bus.PADDR, m_bus.PWDATA);
    end
    n_cmp++;
    if (s_bus.PREADY !== '0 || s_bus.PRDATA !== '0) begin
      n_bad++;
      $display("FAIL reset_response: got pready %b prdata %h, required 0", s_bus.PREADY, s_bus.PRDATA);
    end
    n_cmp++;
    if (grant !== '0 || timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_grant: got grant %b terr %b, required 0 0", grant, timeout_err);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int gi;
    int left;
    logic [15:0] a;
    glog.delete();
    pulse_cyc.delete();
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      a = 16'h0200 + 16'(c * 16);
      set_core(c, a, c[0], 16'h1000 + 16'(c));
      rem[c] = (c == 0) ? 2 : 1;
    end
    for (int c = 0; c < NC; c++) begin
      a = 16'h0200 + 16'(c * 16);
      push_exp(c, a, c[0], 16'h1000 + 16'(c), slave_data(a));
    end
    push_exp(0, 16'h0200, 1'b0, 16'h1000, slave_data(16'h0200));
    left = 5;
    for (int k = 0; k < 60 && left > 0; k++) begin
      @(negedge clk);
      if (|grant) begin
        gi = 0;
        for (int c = 0; c < NC; c++) if (grant[c]) gi = c;
        n_cmp++;
        if (m_bus.PADDR !== c_paddr[gi*BW +: BW]) begin
          n_bad++;
          $display("FAIL cont_paddr: got %h, required %h (core %0d)", m_bus.PADDR, c_paddr[gi*BW +: BW], gi);
        end
      end
      for (int c = 0; c < NC; c++) begin
        if (s_bus.PREADY[c] && rem[c] > 0) begin
          rem[c]--;
          left--;
          glog.push_back(c);
          pulse_cyc.push_back(cyc);
          if (rem[c] == 0) c_psel[c] = 1'b0;
        end
      end
    end
    n_cmp++;
    if (glog.size() != 5) begin
      n_bad++;
      $display("FAIL cont_count: got %0d transfers, required 5", glog.size());
      c_psel = '0;
      for (int c = 0; c < NC; c++) rem[c] = 0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (glog[i] != (i % NC)) begin
          n_bad++;
          $display("FAIL cont_order[%0d]: got core %0d, required core %0d", i, glog[i], i % NC);
        end
      end
      // Pulse spacing covers IDLE, SETUP and ACCESS of the next grant.
      for (int i = 1; i < 5; i++) begin
        n_cmp++;
        if (pulse_cyc[i] - pulse_cyc[i-1] != 3) begin
          n_bad++;
          $display("FAIL cont_spacing[%0d]: got %0d cycles, required 3", i, pulse_cyc[i] - pulse_cyc[i-1]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_single_write();
    @(negedge clk);
    set_core(2, 16'h0104, 1'b1, 16'hBEEF);
    push_exp(2, 16'h0104, 1'b1, 16'hBEEF, slave_data(16'h0104));
    @(negedge clk);
    n_cmp++;
    if ({m_bus.PSELx[0], m_bus.PENABLE[0]} !== 2'b10 || grant !== 4'b0100 || s_bus.PREADY !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_setup: got sel/en %b%b grant %b pready %b, required 10 0100 0000",
               m_bus.PSELx[0], m_bus.PENABLE[0], grant, s_bus.PREADY);
    end
    @(negedge clk);
    n_cmp++;
    if ({m_bus.PSELx[0], m_bus.PENABLE[0]} !== 2'b11 || grant !== 4'b0100 || s_bus.PREADY !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_access: got sel/en %b%b grant %b pready %b, required 11 0100 0100",
               m_bus.PSELx[0], m_bus.PENABLE[0], grant, s_bus.PREADY);
    end
    c_psel[2] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({m_bus.PSELx[0], m_bus.PENABLE[0]} !== 2'b00 || grant !== 4'b0000 || s_bus.PREADY !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_idle: got sel/en %b%b grant %b pready %b, required 00 0000 0000",
               m_bus.PSELx[0], m_bus.PENABLE[0], grant, s_bus.PREADY);
    end
  endtask

  task automatic test_read_wait();
    logic [NC-1:0] want;
    slave_wait = 2;
    @(negedge clk);
    set_core(1, 16'h0010, 1'b0, 16'h0000);
    push_exp(1, 16'h0010, 1'b0, 16'h0000, 16'h1234);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      want = (k == 4) ? 4'b0010 : 4'b0000;
      n_cmp++;
      if (s_bus.PREADY !== want) begin
        n_bad++;
        $display("FAIL read_pready_cycle%0d: got %b, required %b", k, s_bus.PREADY, want);
      end
    end
    n_cmp++;
    if (s_bus.PRDATA !== 64'h0000_0000_1234_0000) begin
      n_bad++;
      $display("FAIL read_prdata: got %h, required 0000000012340000", s_bus.PRDATA);
    end
    c_psel[1] = 1'b0;
    @(negedge clk);
    slave_wait = 0;
  endtask

  task automatic test_fairness();
    int want[3] = '{0, 3, 0};
    glog.delete();
    @(negedge clk);
    set_core(0, 16'h0600, 1'b1, 16'hAAAA);
    rem[0] = 2;
    push_exp(0, 16'h0600, 1'b1, 16'hAAAA, slave_data(16'h0600));
    @(negedge clk);
    set_core(3, 16'h0630, 1'b0, 16'h5555);
    rem[3] = 1;
    push_exp(3, 16'h0630, 1'b0, 16'h5555, slave_data(16'h0630));
    push_exp(0, 16'h0600, 1'b1, 16'hAAAA, slave_data(16'h0600));
    drain(40);
    n_cmp++;
    if (glog.size() != 3) begin
      n_bad++;
      $display("FAIL fair_count: got %0d transfers, required 3", glog.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (glog[i] != want[i]) begin
          n_bad++;
          $display("FAIL fair_order[%0d]: got core %0d, required core %0d", i, glog[i], want[i]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int acc;
    int hit;
    slave_never = 1'b1;
    acc = 0;
    hit = -1;
    @(negedge clk);
    set_core(1, 16'h0300, 1'b0, 16'h0000);
    push_exp(1, 16'h0300, 1'b0, 16'h0000, 16'hFFFF);
    for (int k = 0; k < 40 && hit < 0; k++) begin
      @(negedge clk);
      if (m_bus.PSELx[0] && m_bus.PENABLE[0]) acc++;
      if (s_bus.PREADY[1]) begin
        hit = acc;
        n_cmp++;
        if (timeout_err !== 1'b0) begin
          n_bad++;
          $display("FAIL to_err_early: got %b, required 0", timeout_err);
        end
        c_psel[1] = 1'b0;
      end
    end
    // Eight stalled ACCESS cycles, then the abort pulse in the ninth.
    n_cmp++;
    if (hit != TO + 1) begin
      n_bad++;
      $display("FAIL to_latency: got pulse in ACCESS cycle %0d, required %0d", hit, TO + 1);
      c_psel[1] = 1'b0;
    end
    slave_never = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (timeout_err !== 1'b1 || m_bus.PSELx[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL to_abort: got terr %b psel %b, required 1 0", timeout_err, m_bus.PSELx[0]);
    end
    set_core(2, 16'h0400, 1'b1, 16'h0F0F);
    rem[2] = 1;
    push_exp(2, 16'h0400, 1'b1, 16'h0F0F, slave_data(16'h0400));
    drain(20);
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_bad++;
      $display("FAIL to_sticky: got %b, required 1", timeout_err);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    slave_never = 1'b1;
    glog.delete();
    @(negedge clk);
    set_core(2, 16'h0500, 1'b1, 16'h7777);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({m_bus.PSELx[0], m_bus.PENABLE[0]} !== 2'b11) begin
      n_bad++;
      $display("FAIL ar_in_access: got sel/en %b%b, required 11", m_bus.PSELx[0], m_bus.PENABLE[0]);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({m_bus.PSELx[0], m_bus.PENABLE[0]} !== 2'b00 || grant !== '0 || s_bus.PREADY !== '0 ||
        timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL ar_immediate: got sel/en %b%b grant %b pready %b terr %b, required all 0",
               m_bus.PSELx[0], m_bus.PENABLE[0], grant, s_bus.PREADY, timeout_err);
    end
    c_psel = '0;
    slave_never = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    set_core(3, 16'h0730, 1'b0, 16'h3333);
    set_core(0, 16'h0700, 1'b1, 16'h0000);
    rem[0] = 1;
    rem[3] = 1;
    push_exp(0, 16'h0700, 1'b1, 16'h0000, slave_data(16'h0700));
    push_exp(3, 16'h0730, 1'b0, 16'h3333, slave_data(16'h0730));
    drain(20);
    n_cmp++;
    if (glog.size() < 1 || glog[0] != 0) begin
      n_bad++;
      $display("FAIL ar_priority: got first core %0d, required 0", (glog.size() > 0) ? glog[0] : -1);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int c = 0; c < NC; c++) rem[c] = 0;
    test_reset();
    test_contention();
    test_single_write();
    test_read_wait();
    test_fairness();
    test_timeout();
    test_async_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d expected responses unserved, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global time limit reached");
  end

endmodule
